// File: rtl/jk_ff_behavioral_if.sv
// JK flip-flop bank bus: per-bit J/K controls in, true and complementary state out.
interface jk_ff_behavioral_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;

   modport master (output j, k, input  q, qbar);
   modport slave  (input  j, k, output q, qbar);
endinterface

// File: rtl/jk_ff_behavioral.sv
// Bank of independent positive-edge JK flip-flops with synchronous active-high reset.
module jk_ff_behavioral #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   jk_ff_behavioral_if.slave       bus
);
   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({bus.j[i], bus.k[i]})
            2'b00:   q_d[i] = q_q[i];
            2'b01:   q_d[i] = 1'b0;
            2'b10:   q_d[i] = 1'b1;
            default: q_d[i] = ~q_q[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) q_q <= RESET_VALUE;
      else       q_q <= q_d;
   end

   // qbar derived from the same register so it can never disagree with q.
   assign bus.q    = q_q;
   assign bus.qbar = ~q_q;
endmodule

// File: tb/tb_jk_ff_behavioral.sv
// Directed bench: 1-bit instance plus two 4-bit instances (zero and non-zero reset value).
module tb_jk_ff_behavioral;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   jk_ff_behavioral_if #(.WIDTH(1)) b1 ();
   jk_ff_behavioral_if #(.WIDTH(4)) b4a ();
   jk_ff_behavioral_if #(.WIDTH(4)) b4b ();

   jk_ff_behavioral #(.WIDTH(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   jk_ff_behavioral #(.WIDTH(4)) u4a (.clk(clk), .reset(reset), .bus(b4a));
   jk_ff_behavioral #(.WIDTH(4), .RESET_VALUE(4'b0101)) u4b (.clk(clk), .reset(reset), .bus(b4b));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic e);
      logic ne;
      ne = ~e;
      chk({tag, ".q"},    {3'b000, b1.q},    {3'b000, e});
      chk({tag, ".qbar"}, {3'b000, b1.qbar}, {3'b000, ne});
   endtask

   task automatic chk4(input string tag, input logic [3:0] ea, input logic [3:0] eb);
      chk({tag, ".a.q"},    b4a.q,    ea);
      chk({tag, ".a.qbar"}, b4a.qbar, ~ea);
      chk({tag, ".b.q"},    b4b.q,    eb);
      chk({tag, ".b.qbar"}, b4b.qbar, ~eb);
   endtask

   task automatic drive1(input logic j, input logic k);
      b1.j = j;
      b1.k = k;
   endtask

   task automatic drive4(input logic [3:0] j, input logic [3:0] k);
      b4a.j = j;  b4a.k = k;
      b4b.j = j;  b4b.k = k;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // hold from power-up: state still undefined, nothing checked
      drive1(1'b0, 1'b0);
      drive4(4'b0000, 4'b0000);
      tick;

      @(negedge clk); drive1(1'b0, 1'b1); tick; chk1("clear", 1'b0);
      @(negedge clk); drive1(1'b1, 1'b0); tick; chk1("set", 1'b1);

      // reset wins over toggle on every instance
      @(negedge clk); reset = 1'b1; drive1(1'b1, 1'b1); drive4(4'b1111, 4'b1111);
      tick; chk1("rst_over_tgl", 1'b0); chk4("rst_over_tgl", 4'b0000, 4'b0101);

      @(negedge clk); reset = 1'b0; drive4(4'b0000, 4'b0000);
      tick; chk1("toggle0", 1'b1);
      tick; chk1("toggle1", 1'b0);
      tick; chk1("toggle2", 1'b1);
      chk4("hold4", 4'b0000, 4'b0101);

      // reset pulse entirely between edges is invisible
      @(negedge clk); drive1(1'b0, 1'b0); reset = 1'b1; #2 reset = 1'b0;
      tick; chk1("rst_pulse", 1'b1);

      // reset held across two edges, set request ignored
      @(negedge clk); reset = 1'b1; drive1(1'b1, 1'b0); drive4(4'b1010, 4'b0101);
      tick; chk1("rst_hold0", 1'b0); chk4("rst_hold0", 4'b0000, 4'b0101);
      tick; chk1("rst_hold1", 1'b0); chk4("rst_hold1", 4'b0000, 4'b0101);

      // first edge after release applies JK to the reset value
      @(negedge clk); reset = 1'b0; drive1(1'b1, 1'b1); drive4(4'b0000, 4'b0000);
      tick; chk1("rel_toggle", 1'b1); chk4("rel_hold", 4'b0000, 4'b0101);

      // per bit: b3 set, b2 clear, b1 toggle, b0 hold
      @(negedge clk); drive1(1'b0, 1'b0); drive4(4'b1010, 4'b0110);
      tick; chk4("mix1", 4'b1010, 4'b1011); chk1("hold_mix", 1'b1);
      tick; chk4("mix2", 4'b1000, 4'b1001);

      @(negedge clk); drive4(4'b0000, 4'b1111);
      tick; chk4("clear_all", 4'b0000, 4'b0000);
      @(negedge clk); drive4(4'b1111, 4'b1111);
      tick; chk4("toggle_all", 4'b1111, 4'b1111);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
